// File: rtl/sng_pkg.sv
// rtl/sng_pkg.sv - shared types and default constants for the stochastic number generator
// Purpose: FSM state enum and default WIDTH/SEED/TAPS values used by sng_if, sng_lfsr and sng_unit.
// Ports: none (package).
package sng_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } sng_state_e;

    localparam int         SNG_WIDTH = 4;
    localparam logic [3:0] SNG_SEED  = 4'b0001;
    localparam logic [3:0] SNG_TAPS  = 4'b1100; // x^4 + x^3 + 1

endpackage

// File: rtl/sng_if.sv
// rtl/sng_if.sv - operand/control/stream bundle between a driver and sng_unit
// Purpose: groups the binary operand, start/stop controls and the stochastic output bit.
// Ports (signals): i_x_bn[WIDTH], i_start_sng, i_stop_sng (driver -> SNG), o_sn_bit (SNG -> driver).
// Modports: master = driver side, slave = sng_unit side.
interface sng_if import sng_pkg::*; #(
    parameter int WIDTH = SNG_WIDTH
) ();
    logic [WIDTH-1:0] i_x_bn;
    logic             i_start_sng;
    logic             i_stop_sng;
    logic             o_sn_bit;

    modport master (
        output i_x_bn,
        output i_start_sng,
        output i_stop_sng,
        input  o_sn_bit
    );

    modport slave (
        input  i_x_bn,
        input  i_start_sng,
        input  i_stop_sng,
        output o_sn_bit
    );
endinterface

// File: rtl/sng_lfsr.sv
// rtl/sng_lfsr.sv - maximal-length Fibonacci LFSR with seed load and zero-lock guard
// Purpose: produces the pseudo-random reference sequence the SNG compares against.
// Ports: clk, rst (sync, active-high, loads SEED), load (loads SEED), en (advance one step),
//        state[WIDTH] (current LFSR value).
module sng_lfsr import sng_pkg::*; #(
    parameter int               WIDTH = SNG_WIDTH,
    parameter logic [WIDTH-1:0] SEED  = SNG_SEED,
    parameter logic [WIDTH-1:0] TAPS  = SNG_TAPS
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             en,
    output logic [WIDTH-1:0] state
);

    logic [WIDTH-1:0] state_q;
    logic [WIDTH-1:0] state_d;

    always_comb begin
        state_d = state_q;
        // All-zero is a fixed point of an XOR LFSR; recover by reseeding.
        if (load || (state_q == '0)) begin
            state_d = SEED;
        end else if (en) begin
            state_d = {state_q[WIDTH-2:0], ^(state_q & TAPS)};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= SEED;
        end else begin
            state_q <= state_d;
        end
    end

    assign state = state_q;

endmodule

// File: rtl/sng_unit.sv
// rtl/sng_unit.sv - stochastic number generator: binary operand to unipolar bitstream
// Purpose: latches x on start and emits (x >= lfsr) each cycle while running, so the
//          density of 1s over one LFSR period is x/(2^WIDTH-1).
// Ports: i_clk_sng (clock), i_rst_sng (sync, active-high reset),
//        bus (sng_if.slave: i_x_bn, i_start_sng, i_stop_sng in; o_sn_bit out).
module sng_unit import sng_pkg::*; #(
    parameter int               WIDTH = SNG_WIDTH,
    parameter logic [WIDTH-1:0] SEED  = SNG_SEED,
    parameter logic [WIDTH-1:0] TAPS  = SNG_TAPS
) (
    input  logic  i_clk_sng,
    input  logic  i_rst_sng,
    sng_if.slave  bus
);

    sng_state_e       state_q;
    sng_state_e       state_d;
    logic [WIDTH-1:0] x_q;
    logic [WIDTH-1:0] x_d;
    logic [WIDTH-1:0] lfsr;
    logic             do_start;
    logic             lfsr_en;

    // Stop outranks start; a start during RUN is a restart from SEED.
    always_comb begin
        do_start = bus.i_start_sng & ~bus.i_stop_sng;
        lfsr_en  = (state_q == RUN) & ~bus.i_stop_sng & ~bus.i_start_sng;
        x_d      = do_start ? bus.i_x_bn : x_q;
    end

    sng_lfsr #(
        .WIDTH (WIDTH),
        .SEED  (SEED),
        .TAPS  (TAPS)
    ) u_lfsr (
        .clk   (i_clk_sng),
        .rst   (i_rst_sng),
        .load  (do_start),
        .en    (lfsr_en),
        .state (lfsr)
    );

    always_ff @(posedge i_clk_sng) begin
        if (i_rst_sng) begin
            state_q <= IDLE;
            x_q     <= '0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (do_start)       state_d = RUN;
            RUN:     if (bus.i_stop_sng) state_d = IDLE;
            default:                     state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.o_sn_bit = (state_q == RUN) && (x_q >= lfsr);
    end

endmodule

// File: tb/tb_sng_unit.sv
// tb/tb_sng_unit.sv - self-checking bench for sng_unit using a scoreboard of expected stream bits
module tb_sng_unit;
    import sng_pkg::*;

    localparam int W = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    sng_if #(.WIDTH(W)) bus ();

    sng_unit #(
        .WIDTH (W),
        .SEED  (4'b0001),
        .TAPS  (4'b1100)
    ) u_dut (
        .i_clk_sng (clk),
        .i_rst_sng (rst),
        .bus       (bus)
    );

    int checks = 0;
    int errors = 0;

    bit exp_q[$];
    int seq  [15] = '{1, 2, 4, 9, 3, 6, 13, 10, 5, 11, 7, 15, 14, 12, 8};
    int pat4 [15] = '{1, 1, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};

    bit m_run = 1'b0;
    int m_x   = 0;
    int m_idx = 0;

    task automatic check_bit(input string tag, input logic got, input logic exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%0b expected=%0b", tag, got, exp);
        end
    endtask

    task automatic check_int(input string tag, input int got, input int exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
        end
    endtask

    // One clock: drive inputs, push the expected post-edge bit, then pop and compare.
    task automatic cyc(input bit r, input bit st, input bit sp, input int x, output logic got);
        bit e;
        rst             = r;
        bus.i_start_sng = st;
        bus.i_stop_sng  = sp;
        bus.i_x_bn      = x[W-1:0];
        if (r || sp) begin
            m_run = 1'b0;
        end else if (st) begin
            m_run = 1'b1;
            m_x   = x;
            m_idx = 0;
        end else if (m_run) begin
            m_idx = (m_idx + 1) % 15;
        end
        e = m_run && (m_x >= seq[m_idx]);
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        got = bus.o_sn_bit;
        check_bit("stream", got, exp_q.pop_front());
    endtask

    initial begin
        logic g;
        int   pc;

        // 1. reset
        cyc(1, 0, 0, 0, g);
        cyc(1, 0, 0, 0, g);
        check_int("rst_state", int'(u_dut.state_q), int'(IDLE));
        check_int("rst_lfsr", int'(u_dut.u_lfsr.state_q), 1);
        check_bit("rst_out", bus.o_sn_bit, 1'b0);
        cyc(0, 0, 0, 7, g);
        check_bit("idle_out", g, 1'b0);

        // 2. x=4 known pattern
        cyc(0, 1, 0, 4, g);
        check_bit("x4_pattern", g, pat4[0][0]);
        for (int i = 1; i < 15; i++) begin
            cyc(0, 0, 0, 4, g);
            check_bit("x4_pattern", g, pat4[i][0]);
        end

        // 3. popcount per period for every x
        for (int x = 0; x < 16; x++) begin
            cyc(0, 1, 0, x, g);
            pc = int'(g);
            for (int i = 1; i < 15; i++) begin
                cyc(0, 0, 0, x, g);
                pc += int'(g);
            end
            check_int("popcount", pc, x);
        end

        // 4. stop mid-stream, then restart with x=2
        cyc(0, 1, 0, 9, g);
        for (int i = 0; i < 4; i++) cyc(0, 0, 0, 9, g);
        cyc(0, 0, 1, 9, g);
        check_bit("stop_out", g, 1'b0);
        cyc(0, 0, 0, 9, g);
        check_int("stop_state", int'(u_dut.state_q), int'(IDLE));
        cyc(0, 1, 0, 2, g); check_bit("x2_b0", g, 1'b1);
        cyc(0, 0, 0, 2, g); check_bit("x2_b1", g, 1'b1);
        cyc(0, 0, 0, 2, g); check_bit("x2_b2", g, 1'b0);
        cyc(0, 0, 0, 2, g); check_bit("x2_b3", g, 1'b0);

        // 5. start+stop together, in RUN and in IDLE
        cyc(0, 1, 1, 7, g);
        check_int("startstop_run", int'(u_dut.state_q), int'(IDLE));
        check_bit("startstop_out", g, 1'b0);
        cyc(0, 1, 1, 7, g);
        check_int("startstop_idle", int'(u_dut.state_q), int'(IDLE));
        // reset during RUN
        cyc(0, 1, 0, 15, g);
        cyc(0, 0, 0, 15, g);
        cyc(0, 0, 0, 15, g);
        cyc(1, 0, 0, 15, g);
        check_int("rst_run_state", int'(u_dut.state_q), int'(IDLE));
        check_bit("rst_run_out", g, 1'b0);
        check_int("rst_run_lfsr", int'(u_dut.u_lfsr.state_q), 1);

        // start held high: restart every cycle
        for (int i = 0; i < 3; i++) begin
            cyc(0, 1, 0, 5, g);
            check_bit("start_held_x5", g, 1'b1);
        end
        for (int i = 0; i < 3; i++) begin
            cyc(0, 1, 0, 0, g);
            check_bit("start_held_x0", g, 1'b0);
        end

        // 6. i_x_bn changes during RUN are ignored
        cyc(0, 1, 0, 4, g);
        check_bit("xchg_pattern", g, pat4[0][0]);
        for (int i = 1; i < 15; i++) begin
            cyc(0, 0, 0, 15, g);
            check_bit("xchg_pattern", g, pat4[i][0]);
        end

        cyc(0, 0, 1, 0, g);
        check_bit("final_stop", g, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
